// File: rtl/md_aligner_apb_if.sv
// -----------------------------------------------------------------------------
// md_aligner_apb_if
// Signal bundle for md_aligner_apb: APB register port, MD RX (byte-stream
// input) and MD TX (aligned byte-stream output).
//   slave  : aligner view (APB slave, RX sink, TX source)
//   master : environment view (APB master, RX source, TX sink)
// Parameters: AW = APB address width, DW = MD data width (32/64/128).
// -----------------------------------------------------------------------------
interface md_aligner_apb_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   localparam int DB = DW / 8;
   localparam int OW = $clog2(DB);
   localparam int SW = OW + 1;

   // APB
   logic [AW-1:0] paddr;
   logic          pwrite;
   logic          psel;
   logic          penable;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic          pslverr;
   logic [DW-1:0] prdata;

   // MD RX
   logic          md_rx_valid;
   logic [DW-1:0] md_rx_data;
   logic [OW-1:0] md_rx_offset;
   logic [SW-1:0] md_rx_size;
   logic          md_rx_ready;
   logic          md_rx_err;

   // MD TX
   logic          md_tx_valid;
   logic [DW-1:0] md_tx_data;
   logic [OW-1:0] md_tx_offset;
   logic [SW-1:0] md_tx_size;
   logic          md_tx_ready;
   logic          md_tx_err;

   modport slave (
      input  paddr, pwrite, psel, penable, pwdata,
      output pready, pslverr, prdata,
      input  md_rx_valid, md_rx_data, md_rx_offset, md_rx_size,
      output md_rx_ready, md_rx_err,
      output md_tx_valid, md_tx_data, md_tx_offset, md_tx_size,
      input  md_tx_ready, md_tx_err
   );

   modport master (
      output paddr, pwrite, psel, penable, pwdata,
      input  pready, pslverr, prdata,
      output md_rx_valid, md_rx_data, md_rx_offset, md_rx_size,
      input  md_rx_ready, md_rx_err,
      input  md_tx_valid, md_tx_data, md_tx_offset, md_tx_size,
      output md_tx_ready, md_tx_err
   );
endinterface

// File: rtl/md_aligner_apb.sv
// -----------------------------------------------------------------------------
// md_aligner_apb
// Byte-stream aligner. RX beats of any legal (size, offset) are packed into a
// circular byte buffer; TX beats are re-emitted at the SIZE/OFFSET held in
// CTRL. Registers: CTRL @0x0 {OFFSET[15:8], SIZE[7:0]},
// STATUS @0x4 {BUF_LVL[31:16], TX_ERR[8], CNT_DROP[7:0]} (W1C bit 8 / bit 9).
// Ports:
//   clk   : clock
//   reset : asynchronous reset, active-high
//   bus   : md_aligner_apb_if.slave (APB, MD RX sink, MD TX source)
// -----------------------------------------------------------------------------
module md_aligner_apb #(
   parameter int AW         = 16,
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 8
) (
   input logic             clk,
   input logic             reset,
   md_aligner_apb_if.slave bus
);
   localparam int DB    = DW / 8;
   localparam int OW    = $clog2(DB);
   localparam int SW    = OW + 1;
   localparam int BYTES = FIFO_DEPTH * DB;
   localparam int PW    = $clog2(BYTES);
   localparam int LW    = PW + 1;

   localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
   localparam logic [AW-1:0] ADDR_STATUS = AW'(4);

   // L(size, offset): each size is tested against a constant divisor so no
   // general-purpose modulo is built.
   function automatic logic f_legal(input int unsigned size, input int unsigned off);
      logic ok;
      ok = 1'b0;
      for (int unsigned s = 1; s <= DB; s++) begin
         if (size == s) ok = ((off + s) <= DB) && (((DB + off) % s) == 0);
      end
      return ok;
   endfunction

   logic [7:0]    r_mem [BYTES];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_lvl;
   logic [SW-1:0] r_ctrl_size;
   logic [OW-1:0] r_ctrl_off;
   logic [7:0]    r_cnt_drop;
   logic          r_tx_err;
   logic          r_tx_valid;
   logic [DW-1:0] r_tx_data;
   logic [OW-1:0] r_tx_off;
   logic [SW-1:0] r_tx_size;

   logic [LW-1:0] w_free;
   logic          w_rx_ready;
   logic          w_rx_fire;
   logic          w_rx_legal;
   logic          w_push;
   logic          w_drop;
   logic [DW-1:0] w_rx_shift;
   logic          w_tx_fire;
   logic          w_load;
   logic [DW-1:0] w_pop_bytes;
   logic [DW-1:0] w_tx_data;
   logic          w_apb_acc;
   logic          w_apb_wr;
   logic          w_sel_ctrl;
   logic          w_sel_status;
   logic          w_ctrl_legal;
   logic          w_ctrl_wr;
   logic          w_err_clr;
   logic          w_drop_clr;
   logic [DW-1:0] w_prdata;
   logic          w_pslverr;

   // ---------------- RX side ----------------
   assign w_free     = LW'(BYTES) - r_lvl;
   assign w_rx_ready = ~reset & (w_free >= LW'(DB));
   assign w_rx_fire  = bus.md_rx_valid & w_rx_ready;
   assign w_rx_legal = f_legal(32'(bus.md_rx_size), 32'(bus.md_rx_offset));
   assign w_push     = w_rx_fire & w_rx_legal;
   assign w_drop     = w_rx_fire & ~w_rx_legal;
   // Move the first valid lane down to lane 0 so byte k is the k-th pushed byte.
   assign w_rx_shift = bus.md_rx_data >> {bus.md_rx_offset, 3'b000};

   // ---------------- TX side ----------------
   assign w_tx_fire = r_tx_valid & bus.md_tx_ready;
   assign w_load    = (r_lvl >= LW'(r_ctrl_size)) & (~r_tx_valid | bus.md_tx_ready);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_pop_bytes = '0;
      for (int k = 0; k < DB; k++) begin
         if (k < int'(r_ctrl_size)) w_pop_bytes[k*8 +: 8] = r_mem[r_rd_ptr + PW'(k)];
      end
   end
   assign w_tx_data = w_pop_bytes << {r_ctrl_off, 3'b000};

   // ---------------- APB ----------------
   assign w_apb_acc    = bus.psel & bus.penable & ~reset;
   assign w_apb_wr     = w_apb_acc & bus.pwrite;
   assign w_sel_ctrl   = (bus.paddr == ADDR_CTRL);
   assign w_sel_status = (bus.paddr == ADDR_STATUS);
   assign w_ctrl_legal = f_legal(32'(bus.pwdata[7:0]), 32'(bus.pwdata[15:8]));
   assign w_ctrl_wr    = w_apb_wr & w_sel_ctrl & w_ctrl_legal;
   assign w_err_clr    = w_apb_wr & w_sel_status & bus.pwdata[8];
   assign w_drop_clr   = w_apb_wr & w_sel_status & bus.pwdata[9];

   always_comb begin
      w_prdata  = '0;
      w_pslverr = 1'b0;
      if (w_apb_acc) begin
         if (w_sel_ctrl) begin
            if (!bus.pwrite) w_prdata[15:0] = {8'(r_ctrl_off), 8'(r_ctrl_size)};
            else             w_pslverr      = ~w_ctrl_legal;
         end else if (w_sel_status) begin
            if (!bus.pwrite) w_prdata[31:0] = {16'(r_lvl), 7'b0, r_tx_err, r_cnt_drop};
         end else begin
            w_pslverr = 1'b1;
         end
      end
   end

   // ---------------- State ----------------
   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_lvl       <= '0;
         r_ctrl_size <= SW'(1);
         r_ctrl_off  <= '0;
         r_cnt_drop  <= '0;
         r_tx_err    <= 1'b0;
         r_tx_valid  <= 1'b0;
         r_tx_data   <= '0;
         r_tx_off    <= '0;
         r_tx_size   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(bus.md_rx_size);
         if (w_load) r_rd_ptr <= r_rd_ptr + PW'(r_ctrl_size);
         r_lvl <= r_lvl + (w_push ? LW'(bus.md_rx_size) : LW'(0))
                        - (w_load ? LW'(r_ctrl_size) : LW'(0));

         // Load takes priority: a beat handshaken this cycle is replaced at once.
         if (w_load) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_tx_data;
            r_tx_off   <= r_ctrl_off;
            r_tx_size  <= r_ctrl_size;
         end else if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
         end

         if (w_ctrl_wr) begin
            r_ctrl_size <= SW'(bus.pwdata[7:0]);
            r_ctrl_off  <= OW'(bus.pwdata[15:8]);
         end

         // Clears come first; an event in the same cycle is not lost.
         if (w_err_clr) r_tx_err <= 1'b0;
         if (w_tx_fire && bus.md_tx_err) r_tx_err <= 1'b1;

         if (w_drop_clr) r_cnt_drop <= 8'd0;
         if (w_drop) r_cnt_drop <= w_drop_clr ? 8'd1
                                 : (r_cnt_drop == 8'hFF) ? 8'hFF : r_cnt_drop + 8'd1;
      end
   end

   // NOTE: the byte store has no reset; pointers and level alone decide which bytes are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int k = 0; k < DB; k++) begin
            if (k < int'(bus.md_rx_size)) r_mem[r_wr_ptr + PW'(k)] <= w_rx_shift[k*8 +: 8];
         end
      end
   end

   assign bus.pready       = w_apb_acc;
   assign bus.pslverr      = w_pslverr;
   assign bus.prdata       = w_prdata;
   assign bus.md_rx_ready  = w_rx_ready;
   assign bus.md_rx_err    = w_drop;
   assign bus.md_tx_valid  = r_tx_valid;
   assign bus.md_tx_data   = r_tx_data;
   assign bus.md_tx_offset = r_tx_off;
   assign bus.md_tx_size   = r_tx_size;
endmodule
